// File: rtl/sum_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sum_mult_seq
//  Purpose  : Sequenced P = (A+B)*(C+D)*(E+F) using one shared 9-bit adder
//             and one shared 18x9 multiplier, with valid/ready on both sides.
//  Options  : SUM_MULT_STAT_EN adds the saturating res_cnt result counter.
//  Revision : 1.0  initial release
// ============================================================================
module sum_mult_seq (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [7:0]  C,
    input  logic [7:0]  D,
    input  logic [7:0]  E,
    input  logic [7:0]  F,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] P,
    output logic        busy
`ifdef SUM_MULT_STAT_EN
    ,
    output logic [15:0] res_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD0 = 3'd1,
        S_ADD1 = 3'd2,
        S_ADD2 = 3'd3,
        S_MUL0 = 3'd4,
        S_MUL1 = 3'd5,
        S_OUT  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_op_a, r_op_b, r_op_c, r_op_d, r_op_e, r_op_f;
    logic [8:0]  r_sum1, r_sum2, r_sum3;
    logic [17:0] r_prod;
    logic [26:0] r_p;

    logic        w_in_hs;
    logic        w_out_hs;

    // Shared datapath operands and results
    logic [7:0]  w_add_x, w_add_y;
    logic [8:0]  w_add_sum;
    logic [17:0] w_mul_a;
    logic [8:0]  w_mul_b;
    logic [26:0] w_mul_p;

    // Handshake flags are decoded from the state register only, so neither
    // in_ready nor out_valid depends combinationally on the other side.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);
    assign P         = r_p;

    assign w_in_hs   = in_valid  && (r_state == S_IDLE);
    assign w_out_hs  = out_ready && (r_state == S_OUT);

    // Shared adder operand select: one addition per ADD state
    always_comb begin
        w_add_x = r_op_a;
        w_add_y = r_op_b;
        case (r_state)
            S_ADD1: begin
                w_add_x = r_op_c;
                w_add_y = r_op_d;
            end
            S_ADD2: begin
                w_add_x = r_op_e;
                w_add_y = r_op_f;
            end
            default: begin
                w_add_x = r_op_a;
                w_add_y = r_op_b;
            end
        endcase
    end

    assign w_add_sum = {1'b0, w_add_x} + {1'b0, w_add_y};

    // Shared multiplier operand select: sum1*sum2 in MUL0, prod*sum3 in MUL1
    always_comb begin
        w_mul_a = {9'd0, r_sum1};
        w_mul_b = r_sum2;
        if (r_state == S_MUL1) begin
            w_mul_a = r_prod;
            w_mul_b = r_sum3;
        end
    end

    // 18x9 product is 27 bits wide; the largest reachable value 510^3 fits.
    assign w_mul_p = {9'd0, w_mul_a} * {18'd0, w_mul_b};

    // State register; reset aborts any computation in flight
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state sequencing through the shared units
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_in_hs)  w_state_nxt = S_ADD0;
            S_ADD0:  w_state_nxt = S_ADD1;
            S_ADD1:  w_state_nxt = S_ADD2;
            S_ADD2:  w_state_nxt = S_MUL0;
            S_MUL0:  w_state_nxt = S_MUL1;
            S_MUL1:  w_state_nxt = S_OUT;
            S_OUT:   if (w_out_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture only on the input handshake; later source changes are ignored
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_op_a <= 8'd0;
            r_op_b <= 8'd0;
            r_op_c <= 8'd0;
            r_op_d <= 8'd0;
            r_op_e <= 8'd0;
            r_op_f <= 8'd0;
        end else if (w_in_hs) begin
            r_op_a <= A;
            r_op_b <= B;
            r_op_c <= C;
            r_op_d <= D;
            r_op_e <= E;
            r_op_f <= F;
        end
    end

    // Partial sums and the intermediate product, one per compute state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sum1 <= 9'd0;
            r_sum2 <= 9'd0;
            r_sum3 <= 9'd0;
            r_prod <= 18'd0;
        end else begin
            case (r_state)
                S_ADD0:  r_sum1 <= w_add_sum;
                S_ADD1:  r_sum2 <= w_add_sum;
                S_ADD2:  r_sum3 <= w_add_sum;
                S_MUL0:  r_prod <= w_mul_p[17:0];
                default: ;
            endcase
        end
    end

    // Result register: written in MUL1, held through OUT and afterwards
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_p <= 27'd0;
        end else if (r_state == S_MUL1) begin
            r_p <= w_mul_p;
        end
    end

`ifdef SUM_MULT_STAT_EN
    logic [15:0] r_res_cnt;

    // Completed-result counter, saturating at all-ones
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_res_cnt <= 16'd0;
        end else if (w_out_hs && (r_res_cnt != 16'hFFFF)) begin
            r_res_cnt <= r_res_cnt + 16'd1;
        end
    end

    assign res_cnt = r_res_cnt;
`endif

endmodule
`default_nettype wire
